// File: rtl/mesi_tb_pkg.sv
// Shared constants and state types for the MESI testbench CPU agent.
// Bus command encodings are ints so each module can size them to its own command width.
package mesi_tb_pkg;

    localparam int unsigned MbusNop     = 0;
    localparam int unsigned MbusWr      = 1;
    localparam int unsigned MbusRd      = 2;
    localparam int unsigned MbusWrBroad = 3;
    localparam int unsigned MbusRdBroad = 4;

    localparam int unsigned CbusNop     = 0;
    localparam int unsigned CbusWrSnoop = 1;
    localparam int unsigned CbusRdSnoop = 2;
    localparam int unsigned CbusEnWr    = 3;
    localparam int unsigned CbusEnRd    = 4;

    typedef enum logic [1:0] {
        MesiI = 2'd0,
        MesiS = 2'd1,
        MesiE = 2'd2,
        MesiM = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        MIdle   = 3'd0,
        MBroad  = 3'd1,
        MWaitEn = 3'd2,
        MAccess = 3'd3,
        MDone   = 3'd4
    } m_state_e;

    typedef enum logic [1:0] {
        CIdle = 2'd0,
        CAck  = 2'd1
    } c_state_e;

    typedef enum logic [1:0] {
        InsNop  = 2'd0,
        InsRd   = 2'd1,
        InsWr   = 2'd2,
        InsRsvd = 2'd3
    } tb_ins_e;

    // Remote write invalidates; remote read demotes an owned line to shared.
    function automatic mesi_e snoop_next(mesi_e cur, logic invalidate);
        if (invalidate) return MesiI;
        if (cur == MesiM || cur == MesiE) return MesiS;
        return cur;
    endfunction

endpackage

// File: rtl/mesi_tb_line_array.sv
// Per-line MESI state and data storage with one local write port and one snoop port.
module mesi_tb_line_array
    import mesi_tb_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned LINE_W    = $clog2(NUM_LINES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LINE_W-1:0]       rd_line,
    output logic [1:0]              rd_state,
    output logic [DATA_WIDTH-1:0]   rd_data,
    input  logic [LINE_W-1:0]       wr_line,
    input  logic                    wr_state_en,
    input  logic [1:0]              wr_state,
    input  logic                    wr_data_en,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic                    snoop_en,
    input  logic                    snoop_inv,
    input  logic [LINE_W-1:0]       snoop_line,
    output logic [2*NUM_LINES-1:0]  states
);

    mesi_e                 state_q [NUM_LINES];
    logic [DATA_WIDTH-1:0] data_q  [NUM_LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                state_q[i] <= MesiI;
                data_q[i]  <= '0;
            end
        end else begin
            if (wr_data_en) data_q[wr_line] <= wr_data;
            if (wr_state_en) state_q[wr_line] <= mesi_e'(wr_state);
            // Last assignment wins, so a snoop on the same line overrides the local write.
            if (snoop_en) state_q[snoop_line] <= snoop_next(state_q[snoop_line], snoop_inv);
        end
    end

    assign rd_state = state_q[rd_line];
    assign rd_data  = data_q[rd_line];

    always_comb begin
        states = '0;
        for (int i = 0; i < NUM_LINES; i++) states[2*i +: 2] = state_q[i];
    end

endmodule

// File: rtl/mesi_tb_cpu_agent.sv
// Testbench CPU agent for the MESI ISC: runs RD/WR instructions over a small line array,
// drives mbus broadcast/access commands and answers cbus snoops and enables.
module mesi_tb_cpu_agent
    import mesi_tb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned MBUS_CMD_WIDTH = 3,
    parameter int unsigned CBUS_CMD_WIDTH = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned LINE_W        = $clog2(NUM_LINES)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 cpu_id_i,
    input  logic [1:0]                 tb_ins_i,
    input  logic [LINE_W-1:0]          tb_ins_addr_i,
    output logic                       tb_ins_ack_o,
    output logic [MBUS_CMD_WIDTH-1:0]  mbus_cmd_o,
    output logic [ADDR_WIDTH-1:0]      mbus_addr_o,
    output logic [DATA_WIDTH-1:0]      mbus_data_o,
    input  logic                       mbus_ack_i,
    input  logic [DATA_WIDTH-1:0]      mbus_data_i,
    input  logic [CBUS_CMD_WIDTH-1:0]  cbus_cmd_i,
    input  logic [ADDR_WIDTH-1:0]      cbus_addr_i,
    output logic                       cbus_ack_o,
    output logic [2:0]                 m_state_o,
    output logic [1:0]                 c_state_o,
    output logic [2*NUM_LINES-1:0]     cache_state_o,
    output logic                       error_o
);

    localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntW = DATA_WIDTH - 2;

    m_state_e                  m_state_q;
    c_state_e                  c_state_q;
    logic [LINE_W-1:0]         op_line_q;
    logic                      op_wr_q;
    logic                      pend_q;
    tb_ins_e                   pend_ins_q;
    logic [LINE_W-1:0]         pend_line_q;
    logic [CntW-1:0]           cnt_q;
    logic [TmoW-1:0]           tmo_q;
    logic                      err_q;
    logic                      ins_ack_q;
    logic                      cbus_ack_q;
    logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_q;
    logic [ADDR_WIDTH-1:0]     mbus_addr_q;

    logic [LINE_W-1:0]     cbus_line;
    logic                  unused_cbus_addr;
    logic                  snoop_fire, en_fire, en_match;
    tb_ins_e               cur_ins;
    logic [LINE_W-1:0]     cur_line;
    logic                  is_rd, is_wr, conflict, local_hit;
    logic [LINE_W-1:0]     rd_line;
    logic [1:0]            rd_state;
    mesi_e                 cur_state;
    logic [DATA_WIDTH-1:0] line_data;
    logic                  lw_state_en, lw_data_en;
    logic [LINE_W-1:0]     lw_line;
    logic [1:0]            lw_state;
    logic [DATA_WIDTH-1:0] lw_data;
    logic                  waiting, progress, tmo_hit;

    assign cbus_line        = cbus_addr_i[LINE_W-1:0];
    assign unused_cbus_addr = ^cbus_addr_i[ADDR_WIDTH-1:LINE_W];

    assign snoop_fire = (c_state_q == CIdle) &&
                        (cbus_cmd_i == CBUS_CMD_WIDTH'(CbusWrSnoop) ||
                         cbus_cmd_i == CBUS_CMD_WIDTH'(CbusRdSnoop));
    assign en_fire    = (c_state_q == CIdle) &&
                        (cbus_cmd_i == CBUS_CMD_WIDTH'(CbusEnWr) ||
                         cbus_cmd_i == CBUS_CMD_WIDTH'(CbusEnRd));
    assign en_match   = (m_state_q == MWaitEn) && (cbus_line == op_line_q) &&
                        (cbus_cmd_i == (op_wr_q ? CBUS_CMD_WIDTH'(CbusEnWr)
                                                : CBUS_CMD_WIDTH'(CbusEnRd)));

    // A deferred instruction is replayed from the pending latch instead of tb_ins_i.
    assign cur_ins   = pend_q ? pend_ins_q : tb_ins_e'(tb_ins_i);
    assign cur_line  = pend_q ? pend_line_q : tb_ins_addr_i;
    assign is_rd     = (cur_ins == InsRd);
    assign is_wr     = (cur_ins == InsWr);
    assign rd_line   = (m_state_q == MIdle) ? cur_line : op_line_q;
    assign cur_state = mesi_e'(rd_state);
    assign conflict  = snoop_fire && (cbus_line == cur_line) && (is_rd || is_wr);
    assign local_hit = is_rd ? (cur_state != MesiI)
                             : (cur_state == MesiM || cur_state == MesiE);

    always_comb begin
        lw_state_en = 1'b0;
        lw_data_en  = 1'b0;
        lw_line     = op_line_q;
        lw_state    = MesiM;
        lw_data     = {cpu_id_i, cnt_q};
        unique case (m_state_q)
            MIdle: begin
                if (!conflict && is_wr && local_hit) begin
                    lw_line     = cur_line;
                    lw_state_en = 1'b1;
                    lw_data_en  = 1'b1;
                end
            end
            // Write data lands in the line before the bus WR so mbus_data_o reads it back.
            MWaitEn: if (en_fire && en_match && op_wr_q) lw_data_en = 1'b1;
            MAccess: begin
                if (mbus_ack_i) begin
                    lw_state_en = 1'b1;
                    if (!op_wr_q) begin
                        lw_state   = MesiS;
                        lw_data_en = 1'b1;
                        lw_data    = mbus_data_i;
                    end
                end
            end
            default: ;
        endcase
    end

    mesi_tb_line_array #(
        .NUM_LINES  (NUM_LINES),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lines (
        .clk         (clk),
        .rst         (rst),
        .rd_line     (rd_line),
        .rd_state    (rd_state),
        .rd_data     (line_data),
        .wr_line     (lw_line),
        .wr_state_en (lw_state_en),
        .wr_state    (lw_state),
        .wr_data_en  (lw_data_en),
        .wr_data     (lw_data),
        .snoop_en    (snoop_fire),
        .snoop_inv   (cbus_cmd_i == CBUS_CMD_WIDTH'(CbusWrSnoop)),
        .snoop_line  (cbus_line),
        .states      (cache_state_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_state_q   <= MIdle;
            op_line_q   <= '0;
            op_wr_q     <= 1'b0;
            pend_q      <= 1'b0;
            pend_ins_q  <= InsNop;
            pend_line_q <= '0;
            cnt_q       <= '0;
            ins_ack_q   <= 1'b0;
            mbus_cmd_q  <= '0;
            mbus_addr_q <= '0;
        end else begin
            unique case (m_state_q)
                MIdle: begin
                    if (conflict) begin
                        pend_q      <= 1'b1;
                        pend_ins_q  <= cur_ins;
                        pend_line_q <= cur_line;
                    end else begin
                        pend_q <= 1'b0;
                        if (is_rd || is_wr) begin
                            op_line_q <= cur_line;
                            op_wr_q   <= is_wr;
                            if (local_hit) begin
                                m_state_q <= MDone;
                                ins_ack_q <= 1'b1;
                                if (is_wr) cnt_q <= cnt_q + CntW'(1);
                            end else begin
                                m_state_q   <= MBroad;
                                mbus_cmd_q  <= is_wr ? MBUS_CMD_WIDTH'(MbusWrBroad)
                                                     : MBUS_CMD_WIDTH'(MbusRdBroad);
                                mbus_addr_q <= ADDR_WIDTH'(cur_line);
                            end
                        end
                    end
                end
                MBroad: begin
                    if (mbus_ack_i) begin
                        m_state_q  <= MWaitEn;
                        mbus_cmd_q <= MBUS_CMD_WIDTH'(MbusNop);
                    end
                end
                MWaitEn: begin
                    if (en_fire && en_match) begin
                        m_state_q  <= MAccess;
                        mbus_cmd_q <= op_wr_q ? MBUS_CMD_WIDTH'(MbusWr) : MBUS_CMD_WIDTH'(MbusRd);
                        if (op_wr_q) cnt_q <= cnt_q + CntW'(1);
                    end
                end
                MAccess: begin
                    if (mbus_ack_i) begin
                        m_state_q   <= MDone;
                        ins_ack_q   <= 1'b1;
                        mbus_cmd_q  <= MBUS_CMD_WIDTH'(MbusNop);
                        mbus_addr_q <= '0;
                    end
                end
                MDone: begin
                    m_state_q <= MIdle;
                    ins_ack_q <= 1'b0;
                end
                default: m_state_q <= MIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_state_q  <= CIdle;
            cbus_ack_q <= 1'b0;
        end else begin
            unique case (c_state_q)
                CIdle: begin
                    if (cbus_cmd_i != '0) begin
                        c_state_q  <= CAck;
                        cbus_ack_q <= 1'b1;
                    end
                end
                CAck: begin
                    c_state_q  <= CIdle;
                    cbus_ack_q <= 1'b0;
                end
                default: c_state_q <= CIdle;
            endcase
        end
    end

    assign waiting  = (m_state_q == MBroad) || (m_state_q == MWaitEn) || (m_state_q == MAccess);
    assign progress = ((m_state_q == MBroad || m_state_q == MAccess) && mbus_ack_i) ||
                      (en_fire && en_match);
    assign tmo_hit  = waiting && !progress && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (!waiting || progress) tmo_q <= '0;
            else if (tmo_q != TmoW'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + TmoW'(1);
            if (tmo_hit || (en_fire && !en_match)) err_q <= 1'b1;
        end
    end

    assign tb_ins_ack_o = ins_ack_q;
    assign mbus_cmd_o   = mbus_cmd_q;
    assign mbus_addr_o  = mbus_addr_q;
    assign mbus_data_o  = (m_state_q == MAccess && op_wr_q) ? line_data : '0;
    assign cbus_ack_o   = cbus_ack_q;
    assign m_state_o    = m_state_q;
    assign c_state_o    = c_state_q;
    assign error_o      = err_q;

endmodule
